m_cp0: RTL and testbench

M_CP0 -- requirements
Module: m_cp0

---
 rtl/m_cp0.sv | 88 ++++++++
 tb/tb_m_cp0.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_cp0.sv
// Coprocessor 0 for the M stage: SR/Cause/EPC/PRId, interrupt and exception
// request generation, mtc0 writes, mfc0 reads and eret EXL clearing.
module m_cp0 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        En,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0]  ADDR_SR    = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE = 5'd13;
    localparam logic [4:0]  ADDR_EPC   = 5'd14;
    localparam logic [4:0]  ADDR_PRID  = 5'd15;
    localparam logic [31:0] PRID_VAL   = 32'h2023_0007;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_epc_wr;

    assign w_int_req = ~r_exl & r_ie & (|(HWInt & r_im));
    assign w_exc_req = ~r_exl & (ExcCodeIn != 5'd0);
    assign Req       = Reset & (w_int_req | w_exc_req);
    assign w_epc_wr  = En & (CP0Addr == ADDR_EPC);

    // Forward a same-cycle mtc0 EPC so an eret right behind it sees the new value.
    assign EPCOut = w_epc_wr ? CP0In : r_epc;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= '0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= HWInt;
            if (Req) begin
                r_exl     <= 1'b1;
                r_bd      <= BDIn;
                r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
                r_epc     <= BDIn ? (VPC - 32'd4) : VPC;
            end else if (EXLClr) begin
                r_exl <= 1'b0;
            end else if (En) begin
                case (CP0Addr)
                    ADDR_SR: begin
                        r_im  <= CP0In[15:10];
                        r_exl <= CP0In[1];
                        r_ie  <= CP0In[0];
                    end
                    ADDR_EPC: r_epc <= CP0In;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        CP0Out = '0;
        case (CP0Addr)
            ADDR_SR:    CP0Out = {16'b0, r_im, 8'b0, r_exl, r_ie};
            ADDR_CAUSE: CP0Out = {r_bd, 15'b0, r_ip, 3'b0, r_exccode, 2'b0};
            ADDR_EPC:   CP0Out = r_epc;
            ADDR_PRID:  CP0Out = PRID_VAL;
            default:    CP0Out = '0;
        endcase
    end

endmodule

// File: tb/tb_m_cp0.sv
// Bench for m_cp0: directed scenarios plus randomized traffic against a
// word-level model of the CP0 register file.
module tb_m_cp0;

    logic        Clk;
    logic        Reset;
    logic        En;
    logic [4:0]  CP0Addr;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_sr, m_cause, m_epc;

    m_cp0 dut (
        .Clk(Clk), .Reset(Reset), .En(En), .CP0Addr(CP0Addr), .CP0In(CP0In),
        .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic m_int();
        return !m_sr[1] && m_sr[0] && ((HWInt & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic m_req();
        return Reset && (m_int() || (!m_sr[1] && ExcCodeIn != 5'd0));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h2023_0007;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_epcout();
        return (En && CP0Addr == 5'd14) ? CP0In : m_epc;
    endfunction

    task automatic idle();
        En = 0; CP0Addr = 5'd0; CP0In = 0; VPC = 32'h3000; BDIn = 0;
        ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
    endtask

    // Advance one rising edge, updating the model from the inputs held across it.
    task automatic step();
        logic [31:0] n_sr, n_cause, n_epc;
        logic r, ir;
        n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
        r = m_req(); ir = m_int();
        if (Reset) begin
            n_cause = (m_cause & ~32'h0000_FC00) | ({26'b0, HWInt} << 10);
            if (r) begin
                n_sr    = m_sr | 32'h2;
                n_cause = ({31'b0, BDIn} << 31) | ({26'b0, HWInt} << 10)
                        | ((ir ? 32'd0 : {27'b0, ExcCodeIn}) << 2);
                n_epc   = VPC - (BDIn ? 32'd4 : 32'd0);
            end else if (EXLClr) begin
                n_sr = m_sr & ~32'h2;
            end else if (En && CP0Addr == 5'd12) begin
                n_sr = CP0In & 32'h0000_FC03;
            end else if (En && CP0Addr == 5'd14) begin
                n_epc = CP0In;
            end
        end
        @(posedge Clk);
        m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 0; idle();
        m_sr = 0; m_cause = 0; m_epc = 0;
        @(negedge Clk); @(negedge Clk);
        #1;
        n_cmp++; if (Req !== 1'b0) begin n_bad++; $display("FAIL reset_req got=%b exp=0", Req); end
        n_cmp++; if (EPCOut !== 32'h0) begin n_bad++; $display("FAIL reset_epcout got=%h exp=0", EPCOut); end
        for (int a = 12; a <= 15; a++) begin
            CP0Addr = 5'(a); #1;
            n_cmp++;
            if (CP0Out !== m_read(5'(a))) begin
                n_bad++; $display("FAIL reset_read%0d got=%h exp=%h", a, CP0Out, m_read(5'(a)));
            end
        end
        Reset = 1; idle();
        step();
    endtask

    task automatic test_interrupt();
        idle(); En = 1; CP0Addr = 5'd12; CP0In = 32'h0000_0401;
        step();
        idle(); HWInt = 6'b000001; VPC = 32'h3010; #1;
        n_cmp++; if (Req !== 1'b1) begin n_bad++; $display("FAIL int_req got=%b exp=1", Req); end
        step();
        CP0Addr = 5'd12; #1;
        n_cmp++; if (CP0Out !== 32'h0000_0403) begin n_bad++; $display("FAIL int_sr got=%h exp=00000403", CP0Out); end
        CP0Addr = 5'd13; #1;
        n_cmp++; if (CP0Out !== 32'h0000_0400) begin n_bad++; $display("FAIL int_cause got=%h exp=00000400", CP0Out); end
        CP0Addr = 5'd14; #1;
        n_cmp++; if (CP0Out !== 32'h0000_3010) begin n_bad++; $display("FAIL int_epc got=%h exp=00003010", CP0Out); end
        n_cmp++; if (Req !== 1'b0) begin n_bad++; $display("FAIL int_exl_mask got=%b exp=0", Req); end
        idle(); EXLClr = 1;
        step();
    endtask

    task automatic test_delay_slot();
        idle(); En = 1; CP0Addr = 5'd12; CP0In = 32'h0;
        step();
        idle(); ExcCodeIn = 5'd12; BDIn = 1; VPC = 32'h3024; #1;
        n_cmp++; if (Req !== 1'b1) begin n_bad++; $display("FAIL bd_req got=%b exp=1", Req); end
        step();
        idle(); CP0Addr = 5'd13; #1;
        n_cmp++; if (CP0Out !== 32'h8000_0030) begin n_bad++; $display("FAIL bd_cause got=%h exp=80000030", CP0Out); end
        CP0Addr = 5'd14; #1;
        n_cmp++; if (CP0Out !== 32'h0000_3020) begin n_bad++; $display("FAIL bd_epc got=%h exp=00003020", CP0Out); end
        CP0Addr = 5'd12; #1;
        n_cmp++; if (CP0Out !== 32'h0000_0002) begin n_bad++; $display("FAIL bd_sr got=%h exp=00000002", CP0Out); end
        idle(); EXLClr = 1;
        step();
    endtask

    task automatic test_priority();
        idle(); En = 1; CP0Addr = 5'd12; CP0In = 32'h0000_0801;
        step();
        idle(); HWInt = 6'b000010; ExcCodeIn = 5'd10; VPC = 32'h3030; #1;
        n_cmp++; if (Req !== 1'b1) begin n_bad++; $display("FAIL prio_req got=%b exp=1", Req); end
        step();
        CP0Addr = 5'd13; #1;
        n_cmp++; if (CP0Out[6:2] !== 5'd0) begin n_bad++; $display("FAIL prio_exccode got=%0d exp=0", CP0Out[6:2]); end
        n_cmp++; if (CP0Out !== 32'h0000_0800) begin n_bad++; $display("FAIL prio_cause got=%h exp=00000800", CP0Out); end
        n_cmp++; if (Req !== 1'b0) begin n_bad++; $display("FAIL prio_exl_mask got=%b exp=0", Req); end
    endtask

    task automatic test_eret_vs_mtc0();
        // EXL=1, IM bit 1 and IE set from the previous scenario.
        idle(); EXLClr = 1; En = 1; CP0Addr = 5'd12; CP0In = 32'h0;
        step();
        idle(); CP0Addr = 5'd12; #1;
        n_cmp++; if (CP0Out !== 32'h0000_0801) begin n_bad++; $display("FAIL eret_sr got=%h exp=00000801", CP0Out); end
        En = 1; CP0Addr = 5'd14; CP0In = 32'h3100; EXLClr = 1; #1;
        n_cmp++; if (EPCOut !== 32'h0000_3100) begin n_bad++; $display("FAIL eret_epcfwd got=%h exp=00003100", EPCOut); end
        step();
        idle(); CP0Addr = 5'd14; #1;
        n_cmp++; if (CP0Out !== m_epc) begin n_bad++; $display("FAIL eret_epc_kept got=%h exp=%h", CP0Out, m_epc); end
    endtask

    task automatic test_flush();
        idle(); En = 1; CP0Addr = 5'd14; CP0In = 32'h5555; ExcCodeIn = 5'd4; VPC = 32'h3200; #1;
        n_cmp++; if (Req !== 1'b1) begin n_bad++; $display("FAIL flush_req got=%b exp=1", Req); end
        step();
        idle(); CP0Addr = 5'd14; #1;
        n_cmp++; if (CP0Out !== 32'h0000_3200) begin n_bad++; $display("FAIL flush_epc got=%h exp=00003200", CP0Out); end
    endtask

    task automatic test_async_reset();
        idle(); En = 1; CP0Addr = 5'd14; CP0In = 32'h3040;
        step();
        idle(); HWInt = 6'h3F; ExcCodeIn = 5'd8;
        #2 Reset = 0;
        m_sr = 0; m_cause = 0; m_epc = 0;
        #1;
        n_cmp++; if (Req !== 1'b0) begin n_bad++; $display("FAIL arst_req got=%b exp=0", Req); end
        n_cmp++; if (EPCOut !== 32'h0) begin n_bad++; $display("FAIL arst_epcout got=%h exp=0", EPCOut); end
        for (int a = 12; a <= 14; a++) begin
            CP0Addr = 5'(a); #0.5;
            n_cmp++;
            if (CP0Out !== 32'h0) begin n_bad++; $display("FAIL arst_read%0d got=%h exp=0", a, CP0Out); end
        end
        @(negedge Clk);
        idle(); Reset = 1;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            En        = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0: CP0Addr = 5'd12;
                1: CP0Addr = 5'd13;
                2: CP0Addr = 5'd14;
                3: CP0Addr = 5'd15;
                default: CP0Addr = 5'($urandom);
            endcase
            CP0In     = $urandom;
            VPC       = $urandom & 32'hFFFF_FFFC;
            BDIn      = 1'($urandom);
            ExcCodeIn = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            HWInt     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            EXLClr    = ($urandom_range(0, 5) == 0);
            #1;
            n_cmp++; if (Req !== m_req()) begin n_bad++; $display("FAIL rnd_req i=%0d got=%b exp=%b", i, Req, m_req()); end
            n_cmp++; if (EPCOut !== m_epcout()) begin n_bad++; $display("FAIL rnd_epcout i=%0d got=%h exp=%h", i, EPCOut, m_epcout()); end
            n_cmp++; if (CP0Out !== m_read(CP0Addr)) begin n_bad++; $display("FAIL rnd_read i=%0d a=%0d got=%h exp=%h", i, CP0Addr, CP0Out, m_read(CP0Addr)); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_delay_slot();
        test_priority();
        test_eret_vs_mtc0();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
